pipe5_writeback_arbiter: RTL and testbench
==========================================

PIPE5_WRITEBACK_ARBITER -- requirements
Module: pipe5_writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the entries per functional-unit result FIFO (power of two, >=2).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 wen_au, wen_mu, wen_du, wen_ls  input  1 each  unit result valid this cycle.
REQ-006 reg_rd_au, reg_rd_mu, reg_rd_du, reg_rd_ls  input  5 each  destination register.
REQ-007 wdata_au, wdata_mu, wdata_du, wdata_ls  input  32 each  result data (word_t).
REQ-008 halt_instr  input  1  halt instruction reached commit.
REQ-009 stall_au, stall_mu, stall_du, stall_ls  output  1 each  unit FIFO full; upstream holds result.
REQ-010 rf_wen  output  1  register-file write strobe.
REQ-011 rf_waddr  output  5  register-file write address.
REQ-012 rf_wdata  output  32  register-file write data.
REQ-013 wb_src  output  2  fu_sel_t of unit granted for current rf write.
REQ-014 halt  output  1  sticky core-halt indication.

Function
REQ-015 Each unit SHALL own a DEPTH-entry FIFO of {rd, data}; push when wen_x && !stall_x && reg_rd_x != 0 && !halt.
REQ-016 Results with reg_rd_x == 0 SHALL be discarded, never enqueued, never stall.
REQ-017 stall_x SHALL equal (count_x == DEPTH), from registered count only; full FIFO stalls even if popped same cycle.
REQ-018 wen_x while stall_x high SHALL be ignored; upstream re-presents it.
REQ-019 Each cycle at most one non-empty FIFO head SHALL be granted by round-robin over order AU, MU, DU, LS, starting after the last granted unit; after reset search starts at AU.
REQ-020 Granted head SHALL be popped on that edge and registered into rf_wen=1, rf_waddr, rf_wdata, wb_src, valid the following cycle; no grant leaves rf_wen=0, other rf outputs hold.
REQ-021 Minimum latency: wen_x sampled at edge k into empty FIFO, rf_wen high in cycle after edge k+1.
REQ-022 Order SHALL be preserved within a unit; cross-unit order is not preserved (upstream scoreboard guarantees no WAW across units).
REQ-023 Simultaneous push and pop on one FIFO SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 halt_instr SHALL set halt_pending; halt SHALL assert the cycle after all four FIFOs are empty and rf_wen is 0 with halt_pending set.
REQ-025 halt SHALL remain 1 until RST; while halt=1 all stall_x=1, no pushes, rf_wen=0.
REQ-026 halt_instr while halt_pending already set SHALL have no further effect.

Reset
REQ-027 RST SHALL clear all FIFO counts/pointers, halt_pending, halt=0, rf_wen=0, rf_waddr=0, rf_wdata=0, wb_src=FU_AU, round-robin pointer to AU; stall_x=0.
REQ-028 RST asserted mid-operation SHALL discard all queued results; no rf write in the cycle after reset.

Structure
REQ-029 fu_sel_t (FU_AU=0, FU_MU=1, FU_DU=2, FU_LS=3) SHALL live in rv32i_types_pkg alongside word_t.
REQ-030 One sub-module, pipe5_wb_fifo (parameter DEPTH, 37-bit entries, push/pop/full/empty/count), SHALL be instantiated four times.
REQ-031 Round-robin arbiter and halt logic SHALL be in the top module.

Verification
REQ-032 Single AU write rd=5, data=0xDEADBEEF at edge 1 -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_src=FU_AU after edge 2, one cycle only.
REQ-033 All four wen same cycle, rd=1..4 -> four consecutive rf writes in order AU,MU,DU,LS, no stall with DEPTH=2.
REQ-034 LS wen held 4 cycles rd=7 while MU saturates arbiter -> stall_ls=1 exactly when count_ls==2; no LS result lost or duplicated.
REQ-035 MU write rd=0 data=0x1234 -> no enqueue, rf_wen stays 0, stall_mu stays 0.
REQ-036 halt_instr with 3 results queued -> three rf writes, then halt=1 next cycle; later wen_au ignored, stall_au=1.
REQ-037 RST pulsed with two DU entries queued -> rf_wen=0 following cycles, stall_du=0, halt=0.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types used by the writeback stage and its result FIFOs.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  // Functional units competing for the register-file write port.
  typedef enum logic [1:0] {
    FU_AU = 2'd0,
    FU_MU = 2'd1,
    FU_DU = 2'd2,
    FU_LS = 2'd3
  } fu_sel_t;

  localparam int NUM_FU     = 4;
  localparam int WB_ENTRY_W = 37;

  // One queued result: destination register plus data (37 bits).
  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_entry_t;

  // Unit that follows f in round-robin order, wrapping LS back to AU.
  function automatic fu_sel_t fu_next(input fu_sel_t f);
    return fu_sel_t'(f + 2'd1);
  endfunction

endpackage

// File: rtl/pipe5_writeback_arbiter_if.sv
// Writeback port bundle: four unit result buses, halt request and the
// register-file write port.
interface pipe5_writeback_arbiter_if;
  import rv32i_types_pkg::*;

  logic     wen_au, wen_mu, wen_du, wen_ls;
  reg_idx_t reg_rd_au, reg_rd_mu, reg_rd_du, reg_rd_ls;
  word_t    wdata_au, wdata_mu, wdata_du, wdata_ls;
  logic     halt_instr;
  logic     stall_au, stall_mu, stall_du, stall_ls;
  logic     rf_wen;
  reg_idx_t rf_waddr;
  word_t    rf_wdata;
  fu_sel_t  wb_src;
  logic     halt;

  modport master (
    output wen_au, wen_mu, wen_du, wen_ls,
    output reg_rd_au, reg_rd_mu, reg_rd_du, reg_rd_ls,
    output wdata_au, wdata_mu, wdata_du, wdata_ls,
    output halt_instr,
    input  stall_au, stall_mu, stall_du, stall_ls,
    input  rf_wen, rf_waddr, rf_wdata, wb_src, halt
  );

  modport slave (
    input  wen_au, wen_mu, wen_du, wen_ls,
    input  reg_rd_au, reg_rd_mu, reg_rd_du, reg_rd_ls,
    input  wdata_au, wdata_mu, wdata_du, wdata_ls,
    input  halt_instr,
    output stall_au, stall_mu, stall_du, stall_ls,
    output rf_wen, rf_waddr, rf_wdata, wb_src, halt
  );

endinterface

// File: rtl/pipe5_wb_fifo.sv
// Per-unit result FIFO of {rd, data}; DEPTH must be a power of two so the
// pointers wrap naturally.
module pipe5_wb_fifo
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WB_ENTRY_W-1:0]   din,
  output logic [WB_ENTRY_W-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WB_ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  // Full is taken from the registered count, so a same-cycle pop never
  // makes room for a push.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves count as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipe5_writeback_arbiter.sv
// Writeback arbiter: four unit result FIFOs share one register-file write
// port through a round-robin grant, with a drain-then-halt sequence.
module pipe5_writeback_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  pipe5_writeback_arbiter_if.slave wb
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_FU-1:0] wen, push, pop, full, empty, stall;
  reg_idx_t          rd    [NUM_FU];
  word_t             wdata [NUM_FU];
  wb_entry_t         head  [NUM_FU];
  logic [CNT_W-1:0]  count [NUM_FU];

  fu_sel_t   rr_ptr;
  logic [2:0] pick;
  logic      grant_vld;
  fu_sel_t   grant_sel;
  wb_entry_t grant_ent;

  logic      rf_wen_p1;
  reg_idx_t  rf_waddr_p1;
  word_t     rf_wdata_p1;
  fu_sel_t   wb_src_p1;
  logic      halt_pending, halt_p1;

  // First requester at or after start, in AU, MU, DU, LS order; returns
  // {found, index}. Scanning from the far end lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [NUM_FU-1:0] req,
                                         input fu_sel_t start);
    logic [2:0] found;
    logic [1:0] idx;
    found = 3'b000;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) found = {1'b1, idx};
    end
    return found;
  endfunction

  assign wen      = {wb.wen_ls, wb.wen_du, wb.wen_mu, wb.wen_au};
  assign rd[0]    = wb.reg_rd_au;
  assign rd[1]    = wb.reg_rd_mu;
  assign rd[2]    = wb.reg_rd_du;
  assign rd[3]    = wb.reg_rd_ls;
  assign wdata[0] = wb.wdata_au;
  assign wdata[1] = wb.wdata_mu;
  assign wdata[2] = wb.wdata_du;
  assign wdata[3] = wb.wdata_ls;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_unit
    // x0 writes are dropped here so they never occupy or stall a FIFO.
    assign push[i]  = wen[i] && !full[i] && (rd[i] != '0) && !halt_p1;
    assign stall[i] = (count[i] == CNT_W'(DEPTH)) || halt_p1;

    pipe5_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({rd[i], wdata[i]}),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );
  end

  // Round-robin grant over non-empty FIFO heads; nothing is granted once halted.
  always_comb begin
    pick      = rr_pick(~empty, rr_ptr);
    grant_vld = pick[2] && !halt_p1;
    grant_sel = fu_sel_t'(pick[1:0]);
    grant_ent = head[grant_sel];
    pop       = '0;
    if (grant_vld) pop[grant_sel] = 1'b1;
  end

  // ---- stage p1: granted head registered onto the register-file port ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr      <= FU_AU;
      rf_wen_p1   <= 1'b0;
      rf_waddr_p1 <= '0;
      rf_wdata_p1 <= '0;
      wb_src_p1   <= FU_AU;
    end else begin
      rf_wen_p1 <= grant_vld;
      if (grant_vld) begin
        rr_ptr      <= fu_next(grant_sel);
        rf_waddr_p1 <= grant_ent.rd;
        rf_wdata_p1 <= grant_ent.data;
        wb_src_p1   <= grant_sel;
      end
    end
  end

  // Halt waits for every FIFO and the write port to go quiet, then sticks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_pending <= 1'b0;
      halt_p1      <= 1'b0;
    end else begin
      if (wb.halt_instr) halt_pending <= 1'b1;
      if (halt_pending && (&empty) && !rf_wen_p1) halt_p1 <= 1'b1;
    end
  end

  assign wb.stall_au = stall[0];
  assign wb.stall_mu = stall[1];
  assign wb.stall_du = stall[2];
  assign wb.stall_ls = stall[3];
  assign wb.rf_wen   = rf_wen_p1;
  assign wb.rf_waddr = rf_waddr_p1;
  assign wb.rf_wdata = rf_wdata_p1;
  assign wb.wb_src   = wb_src_p1;
  assign wb.halt     = halt_p1;

endmodule

// File: tb/tb_pipe5_writeback_arbiter.sv
// Bench for pipe5_writeback_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_pipe5_writeback_arbiter;
  import rv32i_types_pkg::*;

  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pipe5_writeback_arbiter_if wb();

  pipe5_writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .wb  (wb)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus staging, indexed AU=0, MU=1, DU=2, LS=3.
  logic [3:0] t_wen;
  logic [4:0] t_rd   [4];
  word_t      t_data [4];
  logic       t_hi;

  // Reference model: one queue of pending results per unit.
  typedef struct packed {
    logic [4:0] rd;
    word_t      data;
  } ent_t;

  ent_t       mq [4][$];
  int         m_ptr;
  bit         m_rf_wen, m_hpend, m_halt;
  logic [4:0] m_waddr;
  word_t      m_wdata;
  int         m_src;

  typedef struct packed {
    logic [3:0]       wen;
    logic [3:0][4:0]  rd;
    logic [3:0][31:0] data;
    logic             e_wen;
    logic [4:0]       e_addr;
    logic [31:0]      e_data;
    logic [1:0]       e_src;
  } vec_t;

  vec_t tbl [9];

  int         ls_sent, mu_sent, ls_seen, writes;
  bit         saw_st;
  logic [3:0] pre;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] stall_vec();
    return {wb.stall_ls, wb.stall_du, wb.stall_mu, wb.stall_au};
  endfunction

  function automatic vec_t mk(input logic [3:0] wen, input logic [19:0] rd,
                              input logic [127:0] data, input logic e_wen,
                              input logic [4:0] e_addr, input word_t e_data,
                              input logic [1:0] e_src);
    vec_t v;
    v.wen = wen; v.rd = rd; v.data = data;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data; v.e_src = e_src;
    return v;
  endfunction

  task automatic clear_inputs();
    t_wen = '0;
    t_hi  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_rd[i]   = '0;
      t_data[i] = '0;
    end
  endtask

  task automatic drive();
    wb.wen_au = t_wen[0]; wb.reg_rd_au = t_rd[0]; wb.wdata_au = t_data[0];
    wb.wen_mu = t_wen[1]; wb.reg_rd_mu = t_rd[1]; wb.wdata_mu = t_data[1];
    wb.wen_du = t_wen[2]; wb.reg_rd_du = t_rd[2]; wb.wdata_du = t_data[2];
    wb.wen_ls = t_wen[3]; wb.reg_rd_ls = t_rd[3]; wb.wdata_ls = t_data[3];
    wb.halt_instr = t_hi;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_ptr = 0; m_rf_wen = 0; m_hpend = 0; m_halt = 0;
    m_waddr = '0; m_wdata = '0; m_src = 0;
  endtask

  // One clock edge of the behavioural rules, evaluated on pre-edge state.
  task automatic model_edge();
    bit   full_or_halt [4];
    bit   all_empty, new_halt;
    int   g, u;
    ent_t e;
    all_empty = 1;
    for (int i = 0; i < 4; i++) begin
      full_or_halt[i] = (mq[i].size() == DEPTH) || m_halt;
      if (mq[i].size() != 0) all_empty = 0;
    end
    new_halt = m_halt || (m_hpend && all_empty && !m_rf_wen);
    g = -1;
    if (!m_halt)
      for (int k = 0; k < 4; k++) begin
        u = (m_ptr + k) % 4;
        if (g < 0 && mq[u].size() > 0) g = u;
      end
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_rf_wen = 1; m_waddr = e.rd; m_wdata = e.data; m_src = g;
      m_ptr = (g + 1) % 4;
    end else begin
      m_rf_wen = 0;
    end
    for (int i = 0; i < 4; i++)
      if (t_wen[i] && !full_or_halt[i] && t_rd[i] != 0 && !m_halt) begin
        e.rd = t_rd[i]; e.data = t_data[i];
        mq[i].push_back(e);
      end
    m_halt = new_halt;
    if (t_hi) m_hpend = 1;
  endtask

  task automatic check_model();
    logic [3:0] es;
    for (int i = 0; i < 4; i++) es[i] = (mq[i].size() == DEPTH) || m_halt;
    check("rf_wen",   wb.rf_wen,   m_rf_wen);
    check("rf_waddr", wb.rf_waddr, m_waddr);
    check("rf_wdata", wb.rf_wdata, m_wdata);
    check("wb_src",   wb.wb_src,   m_src);
    check("halt",     wb.halt,     m_halt);
    check("stall",    stall_vec(), es);
  endtask

  // Apply staged inputs, advance one edge in both DUT and model, sample #1 later.
  task automatic tick(input bit cmp);
    drive();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_edge();
    #1;
    if (cmp) check_model();
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick(0);
    tick(0);
    RST = 1'b0;
    check("rst_rf_wen",   wb.rf_wen,   0);
    check("rst_rf_waddr", wb.rf_waddr, 0);
    check("rst_rf_wdata", wb.rf_wdata, 0);
    check("rst_wb_src",   wb.wb_src,   FU_AU);
    check("rst_halt",     wb.halt,     0);
    check("rst_stall",    stall_vec(), 0);
  endtask

  initial begin
    // inputs {LS,DU,MU,AU}, expected rf port after the edge
    tbl[0] = mk(4'hF, {5'd4, 5'd3, 5'd2, 5'd1},
                {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001},
                1'b0, 5'd0, 32'h0, 2'd0);
    tbl[1] = mk(4'h0, '0, '0, 1'b1, 5'd1, 32'hA000_0001, 2'd0);
    tbl[2] = mk(4'h0, '0, '0, 1'b1, 5'd2, 32'hA000_0002, 2'd1);
    tbl[3] = mk(4'h0, '0, '0, 1'b1, 5'd3, 32'hA000_0003, 2'd2);
    tbl[4] = mk(4'h0, '0, '0, 1'b1, 5'd4, 32'hA000_0004, 2'd3);
    tbl[5] = mk(4'h1, {5'd0, 5'd0, 5'd0, 5'd5}, {96'h0, 32'hDEAD_BEEF},
                1'b0, 5'd4, 32'hA000_0004, 2'd3);
    tbl[6] = mk(4'h0, '0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd0);
    tbl[7] = mk(4'h2, '0, {64'h0, 32'h0000_1234, 32'h0},
                1'b0, 5'd5, 32'hDEAD_BEEF, 2'd0);
    tbl[8] = mk(4'h0, '0, '0, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd0);

    do_reset();

    for (int i = 0; i < 9; i++) begin
      t_wen = tbl[i].wen;
      t_hi  = 1'b0;
      for (int u = 0; u < 4; u++) begin
        t_rd[u]   = tbl[i].rd[u];
        t_data[u] = tbl[i].data[u];
      end
      tick(0);
      check("vec_rf_wen",   wb.rf_wen,   tbl[i].e_wen);
      check("vec_rf_waddr", wb.rf_waddr, tbl[i].e_addr);
      check("vec_rf_wdata", wb.rf_wdata, tbl[i].e_data);
      check("vec_wb_src",   wb.wb_src,   tbl[i].e_src);
      check("vec_stall",    stall_vec(), 0);
      check("vec_halt",     wb.halt,     0);
    end

    // LS presents four rd=7 results while MU floods the arbiter.
    do_reset();
    ls_sent = 0; mu_sent = 0; ls_seen = 0; saw_st = 0;
    for (int c = 0; c < 30; c++) begin
      clear_inputs();
      if (ls_sent < 4) begin
        t_wen[3] = 1'b1; t_rd[3] = 5'd7; t_data[3] = word_t'(32'h700 + ls_sent);
      end
      if (mu_sent < 12) begin
        t_wen[1] = 1'b1; t_rd[1] = 5'd8; t_data[1] = word_t'(32'h800 + mu_sent);
      end
      pre = stall_vec();
      if (pre[3]) saw_st = 1;
      tick(1);
      if (t_wen[3] && !pre[3]) ls_sent++;
      if (t_wen[1] && !pre[1]) mu_sent++;
      if (wb.rf_wen && wb.wb_src == FU_LS) begin
        check("ls_order", wb.rf_wdata, word_t'(32'h700 + ls_seen));
        ls_seen++;
      end
    end
    check("ls_count", ls_seen, 4);
    check("ls_stall_seen", saw_st, 1);

    // Halt with three results queued: drain, one quiet cycle, then halt.
    do_reset();
    t_wen = 4'b0111;
    t_rd[0] = 5'd1; t_rd[1] = 5'd2; t_rd[2] = 5'd3;
    t_data[0] = 32'h3600_0001; t_data[1] = 32'h3600_0002; t_data[2] = 32'h3600_0003;
    tick(1);
    clear_inputs();
    t_hi = 1'b1;
    writes = 0;
    tick(1);
    t_hi = 1'b0;
    if (wb.rf_wen) writes++;
    for (int c = 0; c < 12 && !wb.halt; c++) begin
      tick(1);
      if (wb.rf_wen) writes++;
    end
    check("halt_writes", writes, 3);
    check("halt_set", wb.halt, 1);
    t_wen[0] = 1'b1; t_rd[0] = 5'd9; t_data[0] = 32'h0BAD_0009;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("halt_stall_au", wb.stall_au, 1);
      check("halt_no_write", wb.rf_wen, 0);
    end

    // Reset with two DU results queued throws them away.
    do_reset();
    t_wen = 4'b0111;
    t_rd[0] = 5'd1; t_rd[1] = 5'd2; t_rd[2] = 5'd10;
    t_data[0] = 32'h11; t_data[1] = 32'h22; t_data[2] = 32'hD0D0_000A;
    tick(1);
    clear_inputs();
    t_wen[2] = 1'b1; t_rd[2] = 5'd11; t_data[2] = 32'hD0D0_000B;
    tick(1);
    check("du_two_queued", wb.stall_du, 1);
    clear_inputs();
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("rst_mid_no_write", wb.rf_wen, 0);
      check("rst_mid_stall_du", wb.stall_du, 0);
      check("rst_mid_halt", wb.halt, 0);
    end

    // Randomized traffic with occasional halt requests and resets.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      t_wen = 4'($urandom);
      for (int u = 0; u < 4; u++) begin
        t_rd[u]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        t_data[u] = $urandom;
      end
      t_hi = ($urandom_range(0, 150) == 0);
      RST  = ($urandom_range(0, 80) == 0);
      tick(1);
      RST = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
